// File: rtl/morph_window_extremum.sv
// Streaming 1-D grey-level erosion (min) / dilation (max) over the last WINDOW_LEN
// accepted samples: shift-register window feeding a registered signed compare tree.
module morph_window_extremum #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned WINDOW_LEN = 8,
  parameter int unsigned MODE       = 0
) (
  input  logic                  clk,
  input  logic                  areset_n,
  input  logic [DATA_WIDTH-1:0] axis_in_tdata,
  input  logic                  axis_in_tvalid,
  output logic                  axis_in_tready,
  output logic [DATA_WIDTH-1:0] axis_out_tdata,
  output logic                  axis_out_tvalid,
  input  logic                  axis_out_tready,
  output logic                  window_full
);

  localparam int unsigned LEVELS = $clog2(WINDOW_LEN);
  localparam int unsigned NPAD   = 1 << LEVELS;
  localparam int unsigned CW     = $clog2(WINDOW_LEN + 1);
  // Identity element: can only win a comparison by tying, so it never alters the result
  localparam logic [DATA_WIDTH-1:0] IDENT = (MODE == 0) ?
    {1'b0, {(DATA_WIDTH-1){1'b1}}} : {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] r_win  [WINDOW_LEN];
  logic [DATA_WIDTH-1:0] w_lvl0 [NPAD];
  logic [DATA_WIDTH-1:0] r_tree [LEVELS][NPAD/2];
  logic [LEVELS:0]       r_vld;
  logic [CW-1:0]         r_cnt;
  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_vld;
  logic                  w_advance;
  logic                  w_accept;
  logic                  w_qual;

  // Left operand wins ties so real samples are preferred over right-side pads
  function automatic logic [DATA_WIDTH-1:0] f_pick(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    if (MODE == 0) return ($signed(a) <= $signed(b)) ? a : b;
    else           return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  assign w_advance = areset_n && (!r_out_vld || axis_out_tready);
  assign w_accept  = axis_in_tvalid && w_advance;
  // Token only once this accept leaves the window holding WINDOW_LEN real samples
  assign w_qual    = w_accept && (r_cnt >= CW'(WINDOW_LEN - 1));

  // Sample window: shifts only on accepted input
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int unsigned k = 0; k < WINDOW_LEN; k++) r_win[k] <= '0;
    end else if (w_accept) begin
      r_win[0] <= axis_in_tdata;
      for (int unsigned k = 1; k < WINDOW_LEN; k++) r_win[k] <= r_win[k-1];
    end
  end

  // Saturating fill counter and sticky window_full flag
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else if (w_accept && (r_cnt != CW'(WINDOW_LEN))) begin
      r_cnt  <= r_cnt + 1'b1;
      r_full <= (r_cnt == CW'(WINDOW_LEN - 1));
    end
  end

  // Window widened to a power of two with identity pads
  always_comb begin
    for (int unsigned k = 0; k < NPAD; k++) w_lvl0[k] = IDENT;
    for (int unsigned k = 0; k < WINDOW_LEN; k++) w_lvl0[k] = r_win[k];
  end

  // Compare tree and its valid pipe, frozen as a whole when not advancing
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int unsigned l = 0; l < LEVELS; l++)
        for (int unsigned j = 0; j < NPAD/2; j++) r_tree[l][j] <= '0;
      r_vld <= '0;
    end else if (w_advance) begin
      r_vld <= {r_vld[LEVELS-1:0], w_qual};
      for (int unsigned j = 0; j < NPAD/2; j++)
        r_tree[0][j] <= f_pick(w_lvl0[2*j], w_lvl0[2*j+1]);
      for (int unsigned l = 1; l < LEVELS; l++)
        for (int unsigned j = 0; j < (NPAD >> (l + 1)); j++)
          r_tree[l][j] <= f_pick(r_tree[l-1][2*j], r_tree[l-1][2*j+1]);
    end
  end

  // Output register: refills from the last tree stage whenever the pipe advances
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
    end else if (w_advance) begin
      r_out_data <= r_tree[LEVELS-1][0];
      r_out_vld  <= r_vld[LEVELS];
    end
  end

  assign axis_in_tready  = w_advance;
  assign axis_out_tdata  = r_out_data;
  assign axis_out_tvalid = r_out_vld;
  assign window_full     = r_full;

endmodule

// File: tb/tb_morph_window_extremum.sv
// Directed bench: four instances (W4 max/min, W5 max/min) share one input stream.
module tb_morph_window_extremum;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          areset_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          out_ready;

  logic          rdy_d4, ov_d4, full_d4;
  logic          rdy_e4, ov_e4, full_e4;
  logic          rdy_d5, ov_d5, full_d5;
  logic          rdy_e5, ov_e5, full_e5;
  logic [DW-1:0] od_d4, od_e4, od_d5, od_e5;

  logic signed [DW-1:0] q_d4[$], q_e4[$], q_d5[$], q_e5[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  morph_window_extremum #(.DATA_WIDTH(DW), .WINDOW_LEN(4), .MODE(1)) u_d4 (
    .clk(clk), .areset_n(areset_n), .axis_in_tdata(in_data), .axis_in_tvalid(in_valid),
    .axis_in_tready(rdy_d4), .axis_out_tdata(od_d4), .axis_out_tvalid(ov_d4),
    .axis_out_tready(out_ready), .window_full(full_d4));
  morph_window_extremum #(.DATA_WIDTH(DW), .WINDOW_LEN(4), .MODE(0)) u_e4 (
    .clk(clk), .areset_n(areset_n), .axis_in_tdata(in_data), .axis_in_tvalid(in_valid),
    .axis_in_tready(rdy_e4), .axis_out_tdata(od_e4), .axis_out_tvalid(ov_e4),
    .axis_out_tready(out_ready), .window_full(full_e4));
  morph_window_extremum #(.DATA_WIDTH(DW), .WINDOW_LEN(5), .MODE(1)) u_d5 (
    .clk(clk), .areset_n(areset_n), .axis_in_tdata(in_data), .axis_in_tvalid(in_valid),
    .axis_in_tready(rdy_d5), .axis_out_tdata(od_d5), .axis_out_tvalid(ov_d5),
    .axis_out_tready(out_ready), .window_full(full_d5));
  morph_window_extremum #(.DATA_WIDTH(DW), .WINDOW_LEN(5), .MODE(0)) u_e5 (
    .clk(clk), .areset_n(areset_n), .axis_in_tdata(in_data), .axis_in_tvalid(in_valid),
    .axis_in_tready(rdy_e5), .axis_out_tdata(od_e5), .axis_out_tvalid(ov_e5),
    .axis_out_tready(out_ready), .window_full(full_e5));

  // Record output transfers mid-cycle, where the next rising edge will consume them
  always @(negedge clk) begin
    if (out_ready && ov_d4) q_d4.push_back(od_d4);
    if (out_ready && ov_e4) q_e4.push_back(od_e4);
    if (out_ready && ov_d5) q_d5.push_back(od_d5);
    if (out_ready && ov_e5) q_e5.push_back(od_e5);
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    areset_n  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    areset_n = 1'b1;
    q_d4.delete(); q_e4.delete(); q_d5.delete(); q_e5.delete();
  endtask

  task automatic test_reset();
    areset_n  = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if ({rdy_d4, rdy_e4, rdy_d5, rdy_e5} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_tready: got %b expected 0000", {rdy_d4, rdy_e4, rdy_d5, rdy_e5});
    end
    n_tests++;
    if ({ov_d4, ov_e4, ov_d5, ov_e5} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_tvalid: got %b expected 0000", {ov_d4, ov_e4, ov_d5, ov_e5});
    end
    n_tests++;
    if ({od_d4, od_e4, od_d5, od_e5} !== 64'd0) begin
      n_fail++; $display("FAIL reset_tdata: got %h expected 0", {od_d4, od_e4, od_d5, od_e5});
    end
    n_tests++;
    if ({full_d4, full_e4, full_d5, full_e5} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_full: got %b expected 0000", {full_d4, full_e4, full_d5, full_e5});
    end
  endtask

  task automatic test_dilation_erosion();
    logic signed [DW-1:0] stim [7];
    logic signed [DW-1:0] exp_d [$];
    logic signed [DW-1:0] exp_e [$];
    stim  = '{1, 5, 2, -3, 0, 0, 0};
    exp_d = '{5, 5, 2, 0};
    exp_e = '{-3, -3, -3, -3};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, stim[i], 1'b1);
      n_tests++;
      if (ov_d4 !== (i >= 6)) begin
        n_fail++; $display("FAIL t1_latency after accept %0d: tvalid %b expected %b", i + 1, ov_d4, (i >= 6));
      end
      n_tests++;
      if (full_e4 !== (i >= 3)) begin
        n_fail++; $display("FAIL t2_window_full after accept %0d: got %b expected %b", i + 1, full_e4, (i >= 3));
      end
    end
    repeat (8) drive(1'b0, '0, 1'b1);
    n_tests++;
    if (q_d4.size() != 4) begin
      n_fail++; $display("FAIL t1_count: got %0d outputs expected 4", q_d4.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (q_d4[i] !== exp_d[i]) begin
          n_fail++; $display("FAIL t1_data[%0d]: got %0d expected %0d", i, q_d4[i], exp_d[i]);
        end
      end
    end
    n_tests++;
    if (q_e4.size() != 4) begin
      n_fail++; $display("FAIL t2_count: got %0d outputs expected 4", q_e4.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (q_e4[i] !== exp_e[i]) begin
          n_fail++; $display("FAIL t2_data[%0d]: got %0d expected %0d", i, q_e4[i], exp_e[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int            s;
    logic          acc;
    logic [DW-1:0] hold_d;
    logic          hold_v;
    apply_reset();
    s = 0;
    for (int c = 0; c < 50; c++) begin
      out_ready = !(c >= 10 && c < 15);
      in_valid  = (s < 20);
      in_data   = DW'(s);
      #1;
      acc    = in_valid && rdy_d4;
      hold_d = od_d4;
      hold_v = ov_d4;
      if (!out_ready) begin
        n_tests++;
        if (rdy_d4 !== 1'b0) begin
          n_fail++; $display("FAIL t3_in_tready cycle %0d: got %b expected 0", c, rdy_d4);
        end
      end
      @(posedge clk);
      #1;
      if (acc) s++;
      if (!out_ready) begin
        n_tests++;
        if (od_d4 !== hold_d || ov_d4 !== hold_v) begin
          n_fail++; $display("FAIL t3_stable cycle %0d: got %0d/%b expected %0d/%b", c, od_d4, ov_d4, hold_d, hold_v);
        end
      end
    end
    out_ready = 1'b1;
    n_tests++;
    if (q_d4.size() != 17) begin
      n_fail++; $display("FAIL t3_count: got %0d outputs expected 17", q_d4.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        n_tests++;
        if (q_d4[i] !== DW'(i + 3)) begin
          n_fail++; $display("FAIL t3_data[%0d]: got %0d expected %0d", i, q_d4[i], i + 3);
        end
      end
    end
  endtask

  task automatic test_odd_padding();
    logic signed [DW-1:0] most_neg;
    logic signed [DW-1:0] most_pos;
    most_neg = 16'sh8000;
    most_pos = 16'sh7fff;
    apply_reset();
    repeat (5) drive(1'b1, most_neg, 1'b1);
    repeat (8) drive(1'b0, '0, 1'b1);
    n_tests++;
    if (q_d5.size() != 1) begin
      n_fail++; $display("FAIL t4_max_count: got %0d outputs expected 1", q_d5.size());
    end else begin
      n_tests++;
      if (q_d5[0] !== most_neg) begin
        n_fail++; $display("FAIL t4_max_data: got %0d expected %0d", q_d5[0], most_neg);
      end
    end
    apply_reset();
    repeat (5) drive(1'b1, most_pos, 1'b1);
    repeat (8) drive(1'b0, '0, 1'b1);
    n_tests++;
    if (q_e5.size() != 1) begin
      n_fail++; $display("FAIL t4_min_count: got %0d outputs expected 1", q_e5.size());
    end else begin
      n_tests++;
      if (q_e5[0] !== most_pos) begin
        n_fail++; $display("FAIL t4_min_data: got %0d expected %0d", q_e5[0], most_pos);
      end
    end
  endtask

  task automatic test_input_gaps();
    logic signed [DW-1:0] stim [5];
    stim = '{7, 3, 9, 4, 8};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, stim[i], 1'b1);
      repeat (2) drive(1'b0, '0, 1'b1);
      if (i < 3) begin
        n_tests++;
        if (q_e4.size() != 0 || ov_e4 !== 1'b0) begin
          n_fail++; $display("FAIL t5_warmup after sample %0d: got %0d outputs tvalid %b expected 0", i + 1, q_e4.size(), ov_e4);
        end
      end
    end
    repeat (8) drive(1'b0, '0, 1'b1);
    n_tests++;
    if (q_e4.size() != 2) begin
      n_fail++; $display("FAIL t5_min_count: got %0d outputs expected 2", q_e4.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (q_e4[i] !== 16'sd3) begin
          n_fail++; $display("FAIL t5_min_data[%0d]: got %0d expected 3", i, q_e4[i]);
        end
      end
    end
    n_tests++;
    if (q_d4.size() != 2) begin
      n_fail++; $display("FAIL t5_max_count: got %0d outputs expected 2", q_d4.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (q_d4[i] !== 16'sd9) begin
          n_fail++; $display("FAIL t5_max_data[%0d]: got %0d expected 9", i, q_d4[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    apply_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, DW'(i), 1'b1);
    in_valid = 1'b0;
    areset_n = 1'b0;
    #1;
    n_tests++;
    if ({rdy_d4, ov_d4, full_d4} !== 3'b000 || od_d4 !== '0) begin
      n_fail++; $display("FAIL t6_async_clear: got rdy/vld/full %b data %0d expected 000 and 0", {rdy_d4, ov_d4, full_d4}, od_d4);
    end
    @(posedge clk);
    #1;
    areset_n = 1'b1;
    repeat (8) drive(1'b0, '0, 1'b1);
    n_tests++;
    if (q_d4.size() != 0) begin
      n_fail++; $display("FAIL t6_flushed: got %0d outputs expected 0", q_d4.size());
    end
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(100 + i), 1'b1);
    repeat (8) drive(1'b0, '0, 1'b1);
    n_tests++;
    if (q_d4.size() != 0 || full_d4 !== 1'b0) begin
      n_fail++; $display("FAIL t6_rewarm: got %0d outputs full %b expected 0 outputs full 0", q_d4.size(), full_d4);
    end
    drive(1'b1, DW'(103), 1'b1);
    repeat (8) drive(1'b0, '0, 1'b1);
    n_tests++;
    if (q_d4.size() != 1) begin
      n_fail++; $display("FAIL t6_first_count: got %0d outputs expected 1", q_d4.size());
    end else begin
      n_tests++;
      if (q_d4[0] !== 16'sd103) begin
        n_fail++; $display("FAIL t6_first_data: got %0d expected 103", q_d4[0]);
      end
    end
  endtask

  initial begin
    areset_n  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_dilation_erosion();
    test_backpressure();
    test_odd_padding();
    test_input_gaps();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
